// File: rtl/ysyx_22040237_idu_stage_if.sv
// Fetch/execute handshake and register-file read bundle for the decode stage.
// slave is the decode-stage side, master the surrounding pipeline/regfile side.
interface ysyx_22040237_idu_stage_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic [31:0]     in_inst;

    logic            rs1_r_en;
    logic            rs2_r_en;
    logic [4:0]      rs1_r_addr;
    logic [4:0]      rs2_r_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_opcode;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [PC_W-1:0] out_op1_jump;
    logic [PC_W-1:0] out_op2_jump;
    logic            out_jump;
    logic            out_branch;
    logic            out_ebreak;
    logic            out_illegal;
    logic            out_rd_w_en;
    logic [4:0]      out_rd_w_addr;

    modport slave (
        input  in_valid, in_pc, in_inst, rs1_data, rs2_data, flush, out_ready,
        output in_ready, rs1_r_en, rs2_r_en, rs1_r_addr, rs2_r_addr,
        output out_valid, out_opcode, out_op1, out_op2, out_op1_jump, out_op2_jump,
        output out_jump, out_branch, out_ebreak, out_illegal, out_rd_w_en, out_rd_w_addr
    );

    modport master (
        output in_valid, in_pc, in_inst, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, rs1_r_en, rs2_r_en, rs1_r_addr, rs2_r_addr,
        input  out_valid, out_opcode, out_op1, out_op2, out_op1_jump, out_op2_jump,
        input  out_jump, out_branch, out_ebreak, out_illegal, out_rd_w_en, out_rd_w_addr
    );
endinterface

// File: rtl/ysyx_22040237_idu_stage.sv
// RV32I/RV64I-subset instruction decode stage: combinational decode of the fetched
// instruction into one registered output slot with a valid/ready handshake on both sides.
module ysyx_22040237_idu_stage #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned PC_W = 32
) (
    input logic                       clk,
    input logic                       rst,
    ysyx_22040237_idu_stage_if.slave  bus
);
    localparam logic [6:0] OpImm  = 7'b0010011;
    localparam logic [6:0] OpReg  = 7'b0110011;
    localparam logic [6:0] OpLui  = 7'b0110111;
    localparam logic [6:0] OpAuip = 7'b0010111;
    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] OpJalr = 7'b1100111;
    localparam logic [6:0] OpBr   = 7'b1100011;
    localparam logic [6:0] OpSys  = 7'b1110011;

    typedef struct packed {
        logic [7:0]      opcode;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [PC_W-1:0] op1_jump;
        logic [PC_W-1:0] op2_jump;
        logic            jump;
        logic            branch;
        logic            ebreak;
        logic            illegal;
        logic            rd_w_en;
        logic [4:0]      rd_w_addr;
    } dec_t;

    logic [31:0]       inst;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    logic signed [11:0] imm_i12;
    logic signed [31:0] imm_u32;
    logic signed [12:0] imm_b13;
    logic signed [20:0] imm_j21;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_u;
    logic [PC_W-1:0]   imm_b;
    logic [PC_W-1:0]   imm_j;
    logic [XLEN-1:0]   shamt;
    logic              shamt_bad;
    logic [7:0]        alu_code;

    dec_t dec;
    dec_t out_q;
    logic out_valid_q;
    logic legal;
    logic writes_rd;
    logic rs1_en;
    logic rs2_en;
    logic in_ready;
    logic accept;

    assign inst    = bus.in_inst;
    assign funct3  = inst[14:12];
    assign funct7  = inst[31:25];
    assign rd      = inst[11:7];
    assign imm_i12 = inst[31:20];
    assign imm_u32 = {inst[31:12], 12'h000};
    assign imm_b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_i   = XLEN'(imm_i12);
    assign imm_u   = XLEN'(imm_u32);
    assign imm_b   = PC_W'(imm_b13);
    assign imm_j   = PC_W'(imm_j21);

    // RV32 only has 5-bit shift amounts; a set inst[25] is then not a valid encoding.
    always_comb begin
        if (XLEN == 64) begin
            shamt     = XLEN'(inst[25:20]);
            shamt_bad = 1'b0;
        end else begin
            shamt     = XLEN'(inst[24:20]);
            shamt_bad = inst[25];
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  alu_code = 8'h01;
            3'b001:  alu_code = 8'h03;
            3'b010:  alu_code = 8'h04;
            3'b011:  alu_code = 8'h05;
            3'b100:  alu_code = 8'h06;
            3'b101:  alu_code = 8'h07;
            3'b110:  alu_code = 8'h09;
            default: alu_code = 8'h0A;
        endcase
    end

    always_comb begin
        dec       = '0;
        legal     = 1'b1;
        writes_rd = 1'b0;
        rs1_en    = 1'b0;
        rs2_en    = 1'b0;
        case (inst[6:0])
            OpImm: begin
                rs1_en     = 1'b1;
                writes_rd  = 1'b1;
                dec.op1    = bus.rs1_data;
                dec.op2    = imm_i;
                dec.opcode = alu_code;
                if (funct3 == 3'b001) begin
                    dec.op2 = shamt;
                    legal   = (inst[31:26] == 6'b0) && !shamt_bad;
                end else if (funct3 == 3'b101) begin
                    dec.op2    = shamt;
                    dec.opcode = inst[30] ? 8'h08 : 8'h07;
                    legal      = ({inst[31], inst[29:26]} == 5'b0) && !shamt_bad;
                end
            end
            OpReg: begin
                rs1_en    = 1'b1;
                rs2_en    = 1'b1;
                writes_rd = 1'b1;
                dec.op1   = bus.rs1_data;
                dec.op2   = bus.rs2_data;
                if (funct7 == 7'h00) begin
                    dec.opcode = alu_code;
                end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
                    dec.opcode = 8'h02;
                end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
                    dec.opcode = 8'h08;
                end else begin
                    legal = 1'b0;
                end
            end
            OpLui, OpAuip: begin
                writes_rd  = 1'b1;
                dec.opcode = 8'h01;
                dec.op1    = inst[5] ? '0 : XLEN'(bus.in_pc);
                dec.op2    = imm_u;
            end
            OpJal, OpJalr: begin
                legal        = inst[3] || (funct3 == 3'b000);
                rs1_en       = !inst[3];
                writes_rd    = 1'b1;
                dec.opcode   = 8'h01;
                dec.op1      = XLEN'(bus.in_pc);
                dec.op2      = XLEN'(4);
                dec.op1_jump = inst[3] ? bus.in_pc : bus.rs1_data[PC_W-1:0];
                dec.op2_jump = inst[3] ? imm_j : imm_i[PC_W-1:0];
                dec.jump     = 1'b1;
            end
            OpBr: begin
                legal        = (funct3[2:1] != 2'b01);
                rs1_en       = 1'b1;
                rs2_en       = 1'b1;
                dec.opcode   = {5'b00100, funct3};
                dec.op1      = bus.rs1_data;
                dec.op2      = bus.rs2_data;
                dec.op1_jump = bus.in_pc;
                dec.op2_jump = imm_b;
                dec.branch   = 1'b1;
            end
            OpSys: begin
                dec.ebreak = (inst == 32'h0010_0073);
                legal      = dec.ebreak;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            writes_rd   = 1'b0;
            rs1_en      = 1'b0;
            rs2_en      = 1'b0;
        end
        dec.rd_w_en   = writes_rd && (rd != 5'd0);
        dec.rd_w_addr = dec.rd_w_en ? rd : 5'd0;
    end

    assign bus.rs1_r_en   = rs1_en;
    assign bus.rs2_r_en   = rs2_en;
    assign bus.rs1_r_addr = rs1_en ? inst[19:15] : 5'd0;
    assign bus.rs2_r_addr = rs2_en ? inst[24:20] : 5'd0;

    assign in_ready     = !rst && !bus.flush && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && in_ready;
    assign bus.in_ready = in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= dec;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_opcode    = out_q.opcode;
    assign bus.out_op1       = out_q.op1;
    assign bus.out_op2       = out_q.op2;
    assign bus.out_op1_jump  = out_q.op1_jump;
    assign bus.out_op2_jump  = out_q.op2_jump;
    assign bus.out_jump      = out_q.jump;
    assign bus.out_branch    = out_q.branch;
    assign bus.out_ebreak    = out_q.ebreak;
    assign bus.out_illegal   = out_q.illegal;
    assign bus.out_rd_w_en   = out_q.rd_w_en;
    assign bus.out_rd_w_addr = out_q.rd_w_addr;
endmodule

// File: tb/tb_ysyx_22040237_idu_stage.sv
// Bench for the decode stage: XLEN=64 and XLEN=32 instances share stimulus and are
// compared each cycle against a mnemonic-level decode model and a one-slot handshake model.
module tb_ysyx_22040237_idu_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;

    always #5 clk = ~clk;

    ysyx_22040237_idu_stage_if #(.XLEN(64), .PC_W(32)) b64 ();
    ysyx_22040237_idu_stage_if #(.XLEN(32), .PC_W(32)) b32 ();

    assign b64.in_valid  = in_valid;
    assign b64.in_pc     = in_pc;
    assign b64.in_inst   = in_inst;
    assign b64.rs1_data  = rs1_data;
    assign b64.rs2_data  = rs2_data;
    assign b64.flush     = flush;
    assign b64.out_ready = out_ready;
    assign b32.in_valid  = in_valid;
    assign b32.in_pc     = in_pc;
    assign b32.in_inst   = in_inst;
    assign b32.rs1_data  = rs1_data[31:0];
    assign b32.rs2_data  = rs2_data[31:0];
    assign b32.flush     = flush;
    assign b32.out_ready = out_ready;

    ysyx_22040237_idu_stage #(.XLEN(64), .PC_W(32)) u_dut64 (.clk(clk), .rst(rst), .bus(b64.slave));
    ysyx_22040237_idu_stage #(.XLEN(32), .PC_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32.slave));

    typedef struct packed {
        logic [7:0]  opcode;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [31:0] j1;
        logic [31:0] j2;
        logic        jump;
        logic        branch;
        logic        ebreak;
        logic        illegal;
        logic        rd_en;
        logic [4:0]  rd;
        logic        rs1_en;
        logic [4:0]  rs1a;
        logic        rs2_en;
        logic [4:0]  rs2a;
    } exp_t;

    // ALU op numbering indexed by funct3 for the funct7=0 variants.
    logic [7:0] alu_tab [8] = '{8'h01, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09, 8'h0A};

    int   checks = 0;
    int   failures = 0;
    logic exp_valid = 1'b0;
    logic zero_chk = 1'b0;
    exp_t rec64 = '0;
    exp_t rec32 = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                   input logic [63:0] r1, input logic [63:0] r2, input int xlen);
        exp_t        e;
        logic        ok;
        logic        wr;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [63:0] imm_i;
        logic [63:0] imm_u;
        logic [31:0] imm_b;
        logic [31:0] imm_j;
        logic [63:0] sh;
        e     = '0;
        ok    = 1'b1;
        wr    = 1'b0;
        f7    = inst[31:25];
        f3    = inst[14:12];
        imm_i = 64'($signed(inst) >>> 20);
        imm_u = 64'($signed({inst[31:12], 12'h000}));
        imm_b = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        imm_j = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        sh    = (xlen == 64) ? 64'(inst[25:20]) : 64'(inst[24:20]);
        case (inst[6:0])
            7'h13: begin
                e.rs1_en = 1'b1; wr = 1'b1; e.op1 = r1; e.op2 = imm_i;
                e.opcode = alu_tab[f3];
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.op2 = sh;
                    if (xlen == 32 && inst[25]) ok = 1'b0;
                    if (f3 == 3'd1) ok = ok && (f7[6:1] == 6'h00);
                    else if (f7[6:1] == 6'h10) e.opcode = 8'h08;
                    else if (f7[6:1] != 6'h00) ok = 1'b0;
                end
            end
            7'h33: begin
                e.rs1_en = 1'b1; e.rs2_en = 1'b1; wr = 1'b1; e.op1 = r1; e.op2 = r2;
                if (f7 == 7'h00) e.opcode = alu_tab[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) e.opcode = 8'h02;
                else if (f7 == 7'h20 && f3 == 3'd5) e.opcode = 8'h08;
                else ok = 1'b0;
            end
            7'h37: begin wr = 1'b1; e.opcode = 8'h01; e.op2 = imm_u; end
            7'h17: begin wr = 1'b1; e.opcode = 8'h01; e.op1 = 64'(pc); e.op2 = imm_u; end
            7'h6F: begin
                wr = 1'b1; e.opcode = 8'h01; e.op1 = 64'(pc); e.op2 = 64'd4;
                e.j1 = pc; e.j2 = imm_j; e.jump = 1'b1;
            end
            7'h67: begin
                ok = (f3 == 3'd0); e.rs1_en = 1'b1; wr = 1'b1; e.opcode = 8'h01;
                e.op1 = 64'(pc); e.op2 = 64'd4; e.j1 = r1[31:0]; e.j2 = imm_i[31:0]; e.jump = 1'b1;
            end
            7'h63: begin
                ok = !(f3 == 3'd2 || f3 == 3'd3); e.rs1_en = 1'b1; e.rs2_en = 1'b1;
                e.op1 = r1; e.op2 = r2; e.j1 = pc; e.j2 = imm_b; e.branch = 1'b1;
                e.opcode = 8'h20 | 8'(f3);
            end
            7'h73: begin
                if (inst == 32'h0010_0073) e.ebreak = 1'b1;
                else ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e = '0; e.illegal = 1'b1; wr = 1'b0;
        end
        e.rs1a  = e.rs1_en ? inst[19:15] : 5'd0;
        e.rs2a  = e.rs2_en ? inst[24:20] : 5'd0;
        e.rd_en = wr && (inst[11:7] != 5'd0);
        e.rd    = e.rd_en ? inst[11:7] : 5'd0;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0, 1: r[6:0] = 7'h13;
            2: begin
                r[6:0] = 7'h13;
                r[14:12] = $urandom_range(0, 1) ? 3'd1 : 3'd5;
                r[31:26] = ($urandom_range(0, 3) == 0) ? r[31:26] :
                           ($urandom_range(0, 1) ? 6'h00 : 6'h10);
            end
            3, 4: begin
                r[6:0] = 7'h33;
                if ($urandom_range(0, 3) != 0) r[31:25] = $urandom_range(0, 1) ? 7'h00 : 7'h20;
            end
            5: r[6:0] = 7'h37;
            6: r[6:0] = 7'h17;
            7: r[6:0] = 7'h6F;
            8: begin
                r[6:0] = 7'h67;
                if ($urandom_range(0, 3) != 0) r[14:12] = 3'd0;
            end
            9: r[6:0] = 7'h63;
            10: r = 32'h0010_0073;
            default: ;
        endcase
        return r;
    endfunction

    task automatic chk_out();
        check("out_valid64", 64'(b64.out_valid), 64'(exp_valid));
        check("out_valid32", 64'(b32.out_valid), 64'(exp_valid));
        if (exp_valid || zero_chk) begin
            check("opcode64", 64'(b64.out_opcode), 64'(rec64.opcode));
            check("op1_64", b64.out_op1, rec64.op1);
            check("op2_64", b64.out_op2, rec64.op2);
            check("op1_jump64", 64'(b64.out_op1_jump), 64'(rec64.j1));
            check("op2_jump64", 64'(b64.out_op2_jump), 64'(rec64.j2));
            check("flags64", 64'({b64.out_jump, b64.out_branch, b64.out_ebreak, b64.out_illegal}),
                  64'({rec64.jump, rec64.branch, rec64.ebreak, rec64.illegal}));
            check("rd64", 64'({b64.out_rd_w_en, b64.out_rd_w_addr}), 64'({rec64.rd_en, rec64.rd}));
            check("opcode32", 64'(b32.out_opcode), 64'(rec32.opcode));
            check("op1_32", 64'(b32.out_op1), 64'(rec32.op1[31:0]));
            check("op2_32", 64'(b32.out_op2), 64'(rec32.op2[31:0]));
            check("op1_jump32", 64'(b32.out_op1_jump), 64'(rec32.j1));
            check("op2_jump32", 64'(b32.out_op2_jump), 64'(rec32.j2));
            check("flags32", 64'({b32.out_jump, b32.out_branch, b32.out_ebreak, b32.out_illegal}),
                  64'({rec32.jump, rec32.branch, rec32.ebreak, rec32.illegal}));
            check("rd32", 64'({b32.out_rd_w_en, b32.out_rd_w_addr}), 64'({rec32.rd_en, rec32.rd}));
        end
    endtask

    // One clock: check combinational ports, advance the reference, check registered ports.
    task automatic step();
        exp_t d64;
        exp_t d32;
        logic exp_ready;
        #1;
        d64 = model(in_inst, in_pc, rs1_data, rs2_data, 64);
        d32 = model(in_inst, in_pc, rs1_data, rs2_data, 32);
        exp_ready = !rst && !flush && (!exp_valid || out_ready);
        check("in_ready64", 64'(b64.in_ready), 64'(exp_ready));
        check("in_ready32", 64'(b32.in_ready), 64'(exp_ready));
        check("rs_req64", 64'({b64.rs1_r_en, b64.rs1_r_addr, b64.rs2_r_en, b64.rs2_r_addr}),
              64'({d64.rs1_en, d64.rs1a, d64.rs2_en, d64.rs2a}));
        check("rs_req32", 64'({b32.rs1_r_en, b32.rs1_r_addr, b32.rs2_r_en, b32.rs2_r_addr}),
              64'({d32.rs1_en, d32.rs1a, d32.rs2_en, d32.rs2a}));
        @(posedge clk);
        if (rst) begin
            exp_valid = 1'b0; rec64 = '0; rec32 = '0; zero_chk = 1'b1;
        end else if (flush) begin
            exp_valid = 1'b0;
        end else if (in_valid && exp_ready) begin
            exp_valid = 1'b1; rec64 = d64; rec32 = d32; zero_chk = 1'b0;
        end else if (out_ready) begin
            exp_valid = 1'b0;
        end
        #1;
        chk_out();
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic rdy,
                         input logic fl, input logic r);
        in_valid = v; in_inst = inst; out_ready = rdy; flush = fl; rst = r;
        step();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_pc = 32'h8000_0000; in_inst = 32'h0071_8193; rs1_data = 64'd5; rs2_data = 64'd9;
        drive(1'b1, 32'h0071_8193, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'h0071_8193, 1'b1, 1'b0, 1'b1);
        check("reset_in_ready", 64'(b64.in_ready), 64'd0);

        // ADDI x1,x2,-1
        drive(1'b1, 32'hFFF1_0093, 1'b1, 1'b0, 1'b0);
        check("addi_valid", 64'(b64.out_valid), 64'd1);
        check("addi_opcode", 64'(b64.out_opcode), 64'h01);
        check("addi_op1", b64.out_op1, 64'd5);
        check("addi_op2", b64.out_op2, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_rd", 64'({b64.out_rd_w_en, b64.out_rd_w_addr}), 64'h21);

        // JAL x1,+8
        drive(1'b1, 32'h0080_00EF, 1'b1, 1'b0, 1'b0);
        check("jal_op1", b64.out_op1, 64'h8000_0000);
        check("jal_op2", b64.out_op2, 64'd4);
        check("jal_op2_jump", 64'(b64.out_op2_jump), 64'd8);
        check("jal_jump", 64'(b64.out_jump), 64'd1);

        // BNE x1,x2,-4, then a 3-cycle stall behind it
        drive(1'b1, 32'hFE20_9EE3, 1'b1, 1'b0, 1'b0);
        check("bne_opcode", 64'(b64.out_opcode), 64'h21);
        check("bne_op2_jump", 64'(b64.out_op2_jump), 64'hFFFF_FFFC);
        check("bne_rd_w_en", 64'(b64.out_rd_w_en), 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0071_8193, 1'b0, 1'b0, 1'b0);
            check("stall_in_ready", 64'(b64.in_ready), 64'd0);
            check("stall_hold", 64'({b64.out_valid, b64.out_branch, b64.out_opcode}), 64'h3_21);
        end
        drive(1'b1, 32'h0071_8193, 1'b1, 1'b0, 1'b0);
        check("release_next", 64'({b64.out_opcode, b64.out_rd_w_addr}), 64'({8'h01, 5'd3}));
        drive(1'b0, 32'h0071_8193, 1'b1, 1'b0, 1'b0);
        check("drain_valid", 64'(b64.out_valid), 64'd0);

        // Flush while stalled
        drive(1'b1, 32'h0071_8193, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hFFF1_0093, 1'b0, 1'b1, 1'b0);
        check("flush_valid", 64'(b64.out_valid), 64'd0);

        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0, 1'b0);
        check("nop_rd_w_en", 64'(b64.out_rd_w_en), 64'd0);
        drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        check("ones_illegal", 64'({b64.out_illegal, b64.out_opcode}), 64'h1_00);
        // SLLI x1,x1,33: legal shift on RV64, illegal on RV32
        drive(1'b1, 32'h0210_9093, 1'b1, 1'b0, 1'b0);
        check("slli64_opcode", 64'({b64.out_illegal, b64.out_opcode}), 64'h0_03);
        check("slli32_illegal", 64'({b32.out_illegal, b32.out_opcode}), 64'h1_00);
        drive(1'b1, 32'h0010_0073, 1'b1, 1'b0, 1'b0);
        check("ebreak", 64'({b64.out_ebreak, b64.out_illegal}), 64'h2);

        // Reset with an instruction in flight
        drive(1'b1, 32'hFFF1_0093, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0071_8193, 1'b1, 1'b0, 1'b1);
        check("midrst_valid", 64'(b64.out_valid), 64'd0);
        drive(1'b1, 32'h0071_8193, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            in_pc    = $urandom & 32'hFFFF_FFFC;
            rs1_data = {$urandom, $urandom};
            rs2_data = {$urandom, $urandom};
            drive(($urandom_range(0, 3) != 0), rand_inst(), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0000_0013, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
